// File: rtl/counter_scheduler_pkg.sv
// Shared constants and FSM state encoding for the two-requester counter scheduler.
package counter_scheduler_pkg;

  localparam int N_REQ = 2;
  localparam int LEN_W = 3;
  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_scheduler_rr_pick.sv
// Combinational round-robin pick between two requesters; ptr names the requester
// that wins when both are asking.
module rr_pick
  import counter_scheduler_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic             ptr,
  output logic [N_REQ-1:0] pick
);

  always_comb begin
    pick = '0;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = ptr ? 2'b10 : 2'b01;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/counter_scheduler.sv
// Grants one requester at a time a burst of cnt_en cycles on a shared 2-bit counter,
// whose value is shadowed on cnt_val with a wrap pulse on 3->0.
module counter_scheduler
  import counter_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             cnt_en,
  output logic [N_REQ-1:0] done,
  output logic [CNT_W-1:0] cnt_val,
  output logic             wrap
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] remaining, remaining_d;
  logic             ptr, ptr_d;
  logic [N_REQ-1:0] pick;
  logic [N_REQ-1:0] gnt_d, done_d;
  logic             busy_d, cnt_en_d;

  rr_pick u_rr_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick)
  );

  // Every output is computed one cycle ahead here so the registered copy lines up with the state.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining;
    ptr_d       = ptr;
    gnt_d       = gnt;
    busy_d      = busy;
    cnt_en_d    = 1'b0;
    done_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (req != '0) begin
          state_d     = S_GRANT;
          gnt_d       = pick;
          busy_d      = 1'b1;
          remaining_d = pick[1] ? len1 : len0;
        end
      end
      S_GRANT: begin
        if (remaining != '0) begin
          state_d  = S_RUN;
          cnt_en_d = 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = gnt;
        end
      end
      S_RUN: begin
        remaining_d = remaining - LEN_W'(1);
        if (remaining == LEN_W'(1)) begin
          state_d = S_DONE;
          done_d  = gnt;
        end else begin
          cnt_en_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = gnt[0];
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      remaining <= '0;
      ptr       <= 1'b0;
      gnt       <= '0;
      busy      <= 1'b0;
      cnt_en    <= 1'b0;
      done      <= '0;
    end else begin
      state_q   <= state_d;
      remaining <= remaining_d;
      ptr       <= ptr_d;
      gnt       <= gnt_d;
      busy      <= busy_d;
      cnt_en    <= cnt_en_d;
      done      <= done_d;
    end
  end

  // Shadow of the shared counter: it advances on the edges where the registered enable is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_val <= '0;
      wrap    <= 1'b0;
    end else begin
      cnt_val <= cnt_val + CNT_W'(cnt_en);
      wrap    <= cnt_en && (cnt_val == CNT_W'(3));
    end
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Directed self-checking bench for counter_scheduler with hand-computed expected outputs.
module tb_counter_scheduler;

  logic       clk;
  logic       reset;
  logic [1:0] req;
  logic [2:0] len0;
  logic [2:0] len1;
  logic [1:0] gnt;
  logic       busy;
  logic       cnt_en;
  logic [1:0] done;
  logic [1:0] cnt_val;
  logic       wrap;

  int errors = 0;
  int checks = 0;

  counter_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .len0    (len0),
    .len1    (len1),
    .gnt     (gnt),
    .busy    (busy),
    .cnt_en  (cnt_en),
    .done    (done),
    .cnt_val (cnt_val),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic r, input logic [1:0] q, input logic [2:0] l0, input logic [2:0] l1);
    reset = r;
    req   = q;
    len0  = l0;
    len1  = l1;
  endtask

  // Observed vector order: gnt, busy, cnt_en, done, cnt_val, wrap.
  task automatic check_output(input string tag, input logic [1:0] e_gnt, input logic e_busy,
                              input logic e_en, input logic [1:0] e_done, input logic [1:0] e_cnt,
                              input logic e_wrap);
    logic [8:0] obs, expv;
    obs  = {gnt, busy, cnt_en, done, cnt_val, wrap};
    expv = {e_gnt, e_busy, e_en, e_done, e_cnt, e_wrap};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%b expected=%b (gnt,busy,cnt_en,done,cnt_val,wrap)", tag, obs, expv);
    end
  endtask

  initial begin
    logic [1:0] c;
    apply_stimulus(1'b1, 2'b00, 3'd0, 3'd0);
    tick();
    tick();
    check_output("reset_state", 2'b00, 0, 0, 2'b00, 2'd0, 0);

    // Single requester 0, len 3; req dropped and len changed mid-burst must not matter.
    apply_stimulus(1'b0, 2'b01, 3'd3, 3'd0);
    tick();
    check_output("s1_grant", 2'b01, 1, 0, 2'b00, 2'd0, 0);
    apply_stimulus(1'b0, 2'b00, 3'd7, 3'd0);
    tick();
    check_output("s1_run1", 2'b01, 1, 1, 2'b00, 2'd0, 0);
    tick();
    check_output("s1_run2", 2'b01, 1, 1, 2'b00, 2'd1, 0);
    tick();
    check_output("s1_run3", 2'b01, 1, 1, 2'b00, 2'd2, 0);
    tick();
    check_output("s1_done", 2'b01, 1, 0, 2'b01, 2'd3, 0);
    tick();
    check_output("s1_idle", 2'b00, 0, 0, 2'b00, 2'd3, 0);

    // Both requesting from reset: requester 0 first, then 1, with a wrap.
    apply_stimulus(1'b1, 2'b00, 3'd0, 3'd0);
    tick();
    check_output("s2_reset", 2'b00, 0, 0, 2'b00, 2'd0, 0);
    apply_stimulus(1'b0, 2'b11, 3'd2, 3'd2);
    tick();
    check_output("s2_grant0", 2'b01, 1, 0, 2'b00, 2'd0, 0);
    tick();
    check_output("s2_run0a", 2'b01, 1, 1, 2'b00, 2'd0, 0);
    tick();
    check_output("s2_run0b", 2'b01, 1, 1, 2'b00, 2'd1, 0);
    tick();
    check_output("s2_done0", 2'b01, 1, 0, 2'b01, 2'd2, 0);
    tick();
    check_output("s2_idle0", 2'b00, 0, 0, 2'b00, 2'd2, 0);
    tick();
    check_output("s2_grant1", 2'b10, 1, 0, 2'b00, 2'd2, 0);
    tick();
    check_output("s2_run1a", 2'b10, 1, 1, 2'b00, 2'd2, 0);
    tick();
    check_output("s2_run1b", 2'b10, 1, 1, 2'b00, 2'd3, 0);
    apply_stimulus(1'b0, 2'b00, 3'd2, 3'd2);
    tick();
    check_output("s2_done1", 2'b10, 1, 0, 2'b10, 2'd0, 1);
    tick();
    check_output("s2_idle1", 2'b00, 0, 0, 2'b00, 2'd0, 0);

    // Zero-length burst on requester 1.
    apply_stimulus(1'b0, 2'b10, 3'd0, 3'd0);
    tick();
    check_output("s3_grant", 2'b10, 1, 0, 2'b00, 2'd0, 0);
    apply_stimulus(1'b0, 2'b00, 3'd0, 3'd0);
    tick();
    check_output("s3_done", 2'b10, 1, 0, 2'b10, 2'd0, 0);
    tick();
    check_output("s3_idle", 2'b00, 0, 0, 2'b00, 2'd0, 0);

    // Maximum length 7 from cnt_val 0: one wrap, ends at 3.
    apply_stimulus(1'b0, 2'b01, 3'd7, 3'd0);
    tick();
    check_output("s4_grant", 2'b01, 1, 0, 2'b00, 2'd0, 0);
    apply_stimulus(1'b0, 2'b00, 3'd7, 3'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_output($sformatf("s4_run%0d", i), 2'b01, 1, 1, 2'b00, 2'(i % 4), (i == 4));
    end
    tick();
    check_output("s4_done", 2'b01, 1, 0, 2'b01, 2'd3, 0);
    tick();
    check_output("s4_idle", 2'b00, 0, 0, 2'b00, 2'd3, 0);

    // Requester 1 held high with len 1: a grant every 4 cycles.
    apply_stimulus(1'b0, 2'b10, 3'd0, 3'd1);
    c = 2'd3;
    for (int p = 0; p < 3; p++) begin
      tick();
      check_output($sformatf("s5_grant%0d", p), 2'b10, 1, 0, 2'b00, c, 0);
      tick();
      check_output($sformatf("s5_run%0d", p), 2'b10, 1, 1, 2'b00, c, 0);
      tick();
      check_output($sformatf("s5_done%0d", p), 2'b10, 1, 0, 2'b10, c + 2'd1, (c == 2'd3));
      c = c + 2'd1;
      if (p == 2) apply_stimulus(1'b0, 2'b00, 3'd0, 3'd1);
      tick();
      check_output($sformatf("s5_idle%0d", p), 2'b00, 0, 0, 2'b00, c, 0);
    end

    // Serve requester 0 once so ptr favours requester 1, then abort a len-5 burst with reset.
    apply_stimulus(1'b0, 2'b01, 3'd0, 3'd5);
    tick();
    check_output("s6_pre_grant", 2'b01, 1, 0, 2'b00, c, 0);
    apply_stimulus(1'b0, 2'b00, 3'd0, 3'd5);
    tick();
    check_output("s6_pre_done", 2'b01, 1, 0, 2'b01, c, 0);
    tick();
    apply_stimulus(1'b0, 2'b11, 3'd0, 3'd5);
    tick();
    check_output("s6_grant_ptr1", 2'b10, 1, 0, 2'b00, c, 0);
    tick();
    check_output("s6_run1", 2'b10, 1, 1, 2'b00, c, 0);
    tick();
    check_output("s6_run2", 2'b10, 1, 1, 2'b00, c + 2'd1, 0);
    apply_stimulus(1'b1, 2'b11, 3'd0, 3'd5);
    tick();
    check_output("s6_abort", 2'b00, 0, 0, 2'b00, 2'd0, 0);
    apply_stimulus(1'b0, 2'b11, 3'd2, 3'd5);
    tick();
    check_output("s6_ptr_reset", 2'b01, 1, 0, 2'b00, 2'd0, 0);
    apply_stimulus(1'b0, 2'b00, 3'd2, 3'd5);
    tick();
    check_output("s6_no_done", 2'b01, 1, 1, 2'b00, 2'd0, 0);

    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_scheduler.md
COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; both are listed here, clock and reset first.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  2  level request per requester, bit i = requester i.
REQ-005 len0  input  3  requester 0 burst length, latched at grant.
REQ-006 len1  input  3  requester 1 burst length, latched at grant.
REQ-007 gnt  output  2  one-hot grant, 00 when idle.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 cnt_en  output  1  drives the shared counter's count-enable input x.
REQ-010 done  output  2  one-cycle pulse on bit i when requester i's burst ends.
REQ-011 cnt_val  output  2  shadow of the shared counter value {a,b}.
REQ-012 wrap  output  1  one-cycle pulse when cnt_val goes from 3 to 0.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, RUN and DONE, with all outputs registered.
REQ-014 In IDLE with req!=00, the block SHALL go to GRANT on the next edge, asserting the selected gnt bit and latching its len into a 3-bit remaining counter.
REQ-015 Selection SHALL be round-robin: a single requester wins outright; if req=11, the requester indicated by priority pointer ptr wins.
REQ-016 After a burst completes, ptr SHALL point to the requester not just served.
REQ-017 GRANT SHALL last one cycle, then go to RUN if the latched len is not 0, else go directly to DONE (no cnt_en).
REQ-018 RUN SHALL hold cnt_en=1 for exactly len consecutive cycles, decrement remaining each cycle, and go to DONE after the last one.
REQ-019 DONE SHALL last one cycle with cnt_en=0, gnt held and done[i]=1, then return to IDLE with gnt=00.
REQ-020 Latency SHALL be as follows, with req sampled at edge k: gnt high after k; cnt_en after k+1 .. k+len; done after k+len+1; IDLE after k+len+2.
REQ-021 req SHALL be sampled only in IDLE; deasserting req mid-burst SHALL NOT shorten it, and changing len mid-burst SHALL be ignored.
REQ-022 cnt_val SHALL increment modulo 4 on every edge where cnt_en=1 and hold otherwise.
REQ-023 wrap SHALL be 1 for the one cycle following the edge where cnt_val goes 3 to 0.
REQ-024 No burst SHALL ever overlap another; at most one gnt bit SHALL be high.

Reset
REQ-025 While reset=1 at an edge, the block SHALL enter IDLE with ptr=0, remaining=0, and gnt=00, busy=0, cnt_en=0, done=00, cnt_val=00, wrap=0.
REQ-026 Reset SHALL take priority over every transition, including mid-RUN, and an aborted burst SHALL emit no done pulse.

Structure
REQ-027 A shared package SHALL hold the state encoding (2 bits: IDLE=0, GRANT=1, RUN=2, DONE=3), N_REQ=2, LEN_W=3 and CNT_W=2.
REQ-028 Round-robin selection SHALL be one sub-module, rr_pick: req[1:0] and ptr in, one-hot pick[1:0] out, purely combinational.

Verification
REQ-029 Reset, then req=01 with len0=3 -> gnt=01 after edge 1, cnt_en after edges 2-4, cnt_val=1,2,3, done=01 after edge 5, IDLE after edge 6.
REQ-030 From reset, req=11 with len0=len1=2 -> requester 0 served first (cnt_val 2), then requester 1 (cnt_val 3,0), one wrap pulse, done order 01 then 10.
REQ-031 req=10 with len1=0 -> GRANT then DONE, done=10, cnt_en never high, cnt_val unchanged.
REQ-032 reset pulsed during the second RUN cycle of a len=5 burst -> all outputs 0 after that edge, no done pulse, ptr=0.
REQ-033 len0=7 from cnt_val=0 -> seven cnt_en cycles, exactly one wrap, final cnt_val=3.
REQ-034 req=10 held high continuously with len1=1 -> repeated grants to requester 1, one cnt_en cycle per 4-cycle period, never gnt=01.
